flags_unit: RTL and testbench
=============================

// Module: flags_unit
// PURPOSE
//  Condition-code register (CCR) that consumes the ALU's 16-bit outFlags.
//  - Holds Z/N/C and resolves conditional branches from them.
//  - Saves/restores flags across interrupts through a shadow stack.
//  - Sits in EX/MEM, downstream of the ALU; branch_taken feeds fetch redirect.
// PARAMETERS
//  FLAG_W       16  width of alu_flags / flags_out (bit0=Z, bit1=N, bit2=C, rest reserved=0)
//  STACK_DEPTH  2   shadow-stack entries (nested interrupt depth), >=1
// PORTS
//  clk            in   1       system clock, rising edge
//  rst_n          in   1       asynchronous reset, active low
//  alu_flags      in   FLAG_W  flags from ALU outFlags
//  flags_wr_en    in   1       current instruction updates flags
//  flags_wr_mask  in   3       per-flag update enable {C,N,Z}
//  setc           in   1       SETC: force C=1
//  clrc           in   1       CLRC: force C=0
//  branch_valid   in   1       conditional/unconditional jump in this stage
//  branch_cond    in   2       00 JZ, 01 JN, 10 JC, 11 JMP (always)
//  int_save       in   1       interrupt entry: push CCR
//  rti_restore    in   1       RTI: pop CCR
//  ccr            out  3       registered {C,N,Z}
//  flags_out      out  FLAG_W  {13'b0, ccr}
//  branch_taken   out  1       registered, 1-cycle pulse
//  stack_err      out  1       registered, 1-cycle pulse on overflow/underflow/conflict
// BEHAVIOUR
//  - Reset (rst_n=0, async): ccr=0, stack ptr=0, all stack entries=0,
//    branch_taken=0, stack_err=0. Release takes effect on the next clk edge.
//  - Per rising edge, compute next ccr in this order (later steps win):
//    1. nxt = ccr.
//    2. flags_wr_en: nxt[i] = alu_flags[i] where flags_wr_mask[i]=1.
//    3. setc -> nxt[2]=1; clrc -> nxt[2]=0; both -> clrc wins.
//    4. taken conditional branch (JZ/JN/JC) clears the tested flag in nxt.
//       JMP clears nothing.
//    5. rti_restore with stack non-empty: nxt = top entry; ptr--.
//       Overrides steps 1-4.
//  - Branch resolution uses the condition source (see CONFIGURATION).
//    branch_taken <= branch_valid & (cond==11 | src[cond]).
//    Latency is 1 cycle from branch_valid.
//  - int_save: push the pre-edge ccr (step 1 value), ptr++. Steps 2-4 still
//    update ccr in the same edge.
//  - Boundaries:
//    - int_save when full: push dropped, ccr update proceeds, stack_err=1.
//    - rti_restore when empty: ccr follows steps 1-4, ptr stays 0, stack_err=1.
//    - int_save & rti_restore together: restore performed, save dropped,
//      stack_err=1.
//    - branch_valid with no flags_wr_en: the branch tests held ccr.
//    - Reset mid-stack: all entries lost, ptr=0.
//  - Reserved alu_flags bits [FLAG_W-1:3] are ignored.
// CONFIGURATION
//  FLAGS_FORWARD_EN defined:
//    - If flags_wr_en is high in the same cycle as branch_valid, src is the
//      step-3 value (ALU result forwarded).
//    - Otherwise src = ccr.
//  FLAGS_FORWARD_EN undefined:
//    - src = registered ccr only.
//    - Compiler/hazard unit guarantees one bubble between flag write and branch.
// TESTING
//  1. Reset: rst_n=0 mid-cycle -> ccr=000, branch_taken=0, stack_err=0
//     immediately, without waiting for a clk edge.
//  2. flags_wr_en=1, mask=111, alu_flags=16'h0001, then JZ next cycle
//     -> branch_taken=1 one cycle later; ccr Z cleared to 0.
//  3. setc=1 & clrc=1 -> ccr[2]=0. Separately, mask=010 with alu_flags=16'h0007
//     -> only N updates; ccr=010 from 000.
//  4. ccr=101, int_save; ccr=010, int_save; third int_save -> stack_err=1.
//     Then rti x2 -> ccr=010 then 101. Third rti -> stack_err=1, ccr=101.
//  5. Same-cycle flags_wr_en (Z=1) + JZ, ccr Z=0:
//     FLAGS_FORWARD_EN defined -> branch_taken=1.
//     FLAGS_FORWARD_EN undefined -> branch_taken=0.
//  6. JMP with ccr=000 -> branch_taken=1 and ccr unchanged.
//     JC with C=0 -> branch_taken=0.

Source files
------------

// File: rtl/flags_unit_if.sv
// Flags unit bus: ALU flag write, SETC/CLRC, branch and interrupt
// controls in; CCR, flags word, branch result and stack error out.
interface flags_unit_if #(
    parameter int FLAG_W = 16
);
    logic [FLAG_W-1:0] alu_flags;
    logic              flags_wr_en;
    logic [2:0]        flags_wr_mask;
    logic              setc;
    logic              clrc;
    logic              branch_valid;
    logic [1:0]        branch_cond;
    logic              int_save;
    logic              rti_restore;
    logic [2:0]        ccr;
    logic [FLAG_W-1:0] flags_out;
    logic              branch_taken;
    logic              stack_err;

    modport master (
        output alu_flags, flags_wr_en, flags_wr_mask, setc, clrc,
        output branch_valid, branch_cond, int_save, rti_restore,
        input  ccr, flags_out, branch_taken, stack_err
    );

    modport slave (
        input  alu_flags, flags_wr_en, flags_wr_mask, setc, clrc,
        input  branch_valid, branch_cond, int_save, rti_restore,
        output ccr, flags_out, branch_taken, stack_err
    );
endinterface

// File: rtl/flags_unit.sv
// Condition-code register {C,N,Z} with branch resolution and an
// interrupt shadow stack.
// Ports: clk, rst_n (async, active low), bus (flags_unit_if.slave):
//   in  alu_flags, flags_wr_en, flags_wr_mask, setc, clrc,
//       branch_valid, branch_cond, int_save, rti_restore
//   out ccr, flags_out, branch_taken, stack_err (all registered)
// Macro FLAGS_FORWARD_EN: branch tests the same-cycle ALU flags
// when a flag write coincides with the branch.
module flags_unit #(
    parameter int FLAG_W      = 16,
    parameter int STACK_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    flags_unit_if.slave  bus
);
    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam logic [PW-1:0] FULL = PW'(STACK_DEPTH);

    logic [2:0]    ccr_q;
    logic [2:0]    stack_q [STACK_DEPTH];
    logic [PW-1:0] ptr_q;
    logic          taken_q;
    logic          err_q;

    logic [2:0] s2, s3, s4, src, top, nxt;
    logic       is_jmp, cond_hit, taken;
    logic       empty, full, pop_ok, push_ok, err;
    logic       unused_rsvd;

    assign unused_rsvd = ^bus.alu_flags[FLAG_W-1:3];

    always_comb begin
        s2 = ccr_q;
        if (bus.flags_wr_en) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.flags_wr_mask[i]) s2[i] = bus.alu_flags[i];
            end
        end
        s3 = s2;
        if (bus.setc) s3[2] = 1'b1;
        if (bus.clrc) s3[2] = 1'b0;
    end

`ifdef FLAGS_FORWARD_EN
    assign src = (bus.flags_wr_en && bus.branch_valid) ? s3 : ccr_q;
`else
    assign src = ccr_q;
`endif

    assign is_jmp = (bus.branch_cond == 2'b11);

    always_comb begin
        cond_hit = 1'b0;
        case (bus.branch_cond)
            2'b00:   cond_hit = src[0];
            2'b01:   cond_hit = src[1];
            2'b10:   cond_hit = src[2];
            default: cond_hit = 1'b1;
        endcase
    end

    assign taken = bus.branch_valid & cond_hit;

    // A taken conditional branch consumes the flag it tested.
    always_comb begin
        s4 = s3;
        if (taken && !is_jmp) begin
            case (bus.branch_cond)
                2'b00:   s4[0] = 1'b0;
                2'b01:   s4[1] = 1'b0;
                default: s4[2] = 1'b0;
            endcase
        end
    end

    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (PW'(i) == ptr_q - PW'(1)) top = stack_q[i];
        end
    end

    assign empty   = (ptr_q == '0);
    assign full    = (ptr_q == FULL);
    assign pop_ok  = bus.rti_restore & ~empty;
    // Restore wins over a simultaneous save.
    assign push_ok = bus.int_save & ~bus.rti_restore & ~full;
    assign err     = (bus.int_save & bus.rti_restore)
                   | (bus.int_save & full)
                   | (bus.rti_restore & empty);
    assign nxt     = pop_ok ? top : s4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccr_q   <= '0;
            ptr_q   <= '0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            ccr_q   <= nxt;
            taken_q <= taken;
            err_q   <= err;
            if (pop_ok) begin
                ptr_q <= ptr_q - PW'(1);
            end else if (push_ok) begin
                ptr_q <= ptr_q + PW'(1);
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (PW'(i) == ptr_q) stack_q[i] <= ccr_q;
                end
            end
        end
    end

    assign bus.ccr          = ccr_q;
    assign bus.flags_out    = {{(FLAG_W-3){1'b0}}, ccr_q};
    assign bus.branch_taken = taken_q;
    assign bus.stack_err    = err_q;
endmodule

// File: tb/tb_flags_unit.sv
// Directed self-checking bench for flags_unit.
// Expected values are hand-computed per step.
module tb_flags_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    flags_unit_if #(.FLAG_W(16)) bus ();

    flags_unit #(.FLAG_W(16), .STACK_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.alu_flags     = '0;
        bus.flags_wr_en   = 1'b0;
        bus.flags_wr_mask = 3'b000;
        bus.setc          = 1'b0;
        bus.clrc          = 1'b0;
        bus.branch_valid  = 1'b0;
        bus.branch_cond   = 2'b00;
        bus.int_save      = 1'b0;
        bus.rti_restore   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic wr(input logic [2:0] m, input logic [15:0] f);
        bus.flags_wr_en   = 1'b1;
        bus.flags_wr_mask = m;
        bus.alu_flags     = f;
    endtask

    task automatic br(input logic [1:0] c);
        bus.branch_valid = 1'b1;
        bus.branch_cond  = c;
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        check("rst_ccr", 16'(bus.ccr), 16'h0);

        // Load flags, then fill the stack while branching so every
        // output is nonzero before an asynchronous reset.
        wr(3'b111, 16'h0007);
        tick();
        check("load_ccr", 16'(bus.ccr), 16'h7);
        check("load_fout", bus.flags_out, 16'h0007);
        br(2'b11); bus.int_save = 1'b1;
        tick();
        br(2'b11); bus.int_save = 1'b1;
        tick();
        br(2'b11); bus.int_save = 1'b1;
        tick();
        check("pre_rst_taken", 16'(bus.branch_taken), 16'h1);
        check("pre_rst_err", 16'(bus.stack_err), 16'h1);
        check("pre_rst_ccr", 16'(bus.ccr), 16'h7);
        #2 rst_n = 1'b0;
        #1;
        check("async_ccr", 16'(bus.ccr), 16'h0);
        check("async_taken", 16'(bus.branch_taken), 16'h0);
        check("async_err", 16'(bus.stack_err), 16'h0);
        #1 rst_n = 1'b1;
        // Stack was cleared: restore underflows.
        bus.rti_restore = 1'b1;
        tick();
        check("rst_stack_err", 16'(bus.stack_err), 16'h1);
        check("rst_stack_ccr", 16'(bus.ccr), 16'h0);

        // Write Z, JZ next cycle.
        wr(3'b111, 16'h0001);
        tick();
        check("z_set", 16'(bus.ccr), 16'h1);
        check("z_no_br", 16'(bus.branch_taken), 16'h0);
        br(2'b00);
        tick();
        check("jz_taken", 16'(bus.branch_taken), 16'h1);
        check("jz_clear", 16'(bus.ccr), 16'h0);

        // SETC / CLRC / masked write / reserved bits.
        bus.setc = 1'b1;
        tick();
        check("setc", 16'(bus.ccr), 16'h4);
        bus.setc = 1'b1; bus.clrc = 1'b1;
        tick();
        check("setc_clrc", 16'(bus.ccr), 16'h0);
        wr(3'b010, 16'h0007);
        tick();
        check("mask_n", 16'(bus.ccr), 16'h2);
        wr(3'b111, 16'hFFF8);
        tick();
        check("rsvd_fout", bus.flags_out, 16'h0000);

        // Stack push/pop with overflow and underflow.
        wr(3'b111, 16'h0005);
        tick();
        check("ccr_101", 16'(bus.ccr), 16'h5);
        bus.int_save = 1'b1; wr(3'b111, 16'h0002);
        tick();
        check("push1_ccr", 16'(bus.ccr), 16'h2);
        check("push1_err", 16'(bus.stack_err), 16'h0);
        bus.int_save = 1'b1;
        tick();
        check("push2_err", 16'(bus.stack_err), 16'h0);
        bus.int_save = 1'b1; wr(3'b001, 16'h0001);
        tick();
        check("ovf_err", 16'(bus.stack_err), 16'h1);
        check("ovf_ccr", 16'(bus.ccr), 16'h3);
        bus.rti_restore = 1'b1;
        tick();
        check("pop1_ccr", 16'(bus.ccr), 16'h2);
        check("pop1_err", 16'(bus.stack_err), 16'h0);
        bus.rti_restore = 1'b1;
        tick();
        check("pop2_ccr", 16'(bus.ccr), 16'h5);
        bus.rti_restore = 1'b1;
        tick();
        check("unf_err", 16'(bus.stack_err), 16'h1);
        check("unf_ccr", 16'(bus.ccr), 16'h5);
        tick();
        check("err_pulse", 16'(bus.stack_err), 16'h0);

        // Same-cycle write of Z with JZ while held Z=0.
        wr(3'b001, 16'h0000);
        tick();
        check("ccr_100", 16'(bus.ccr), 16'h4);
        wr(3'b111, 16'h0001); br(2'b00);
        tick();
`ifdef FLAGS_FORWARD_EN
        check("fwd_taken", 16'(bus.branch_taken), 16'h1);
        check("fwd_ccr", 16'(bus.ccr), 16'h0);
`else
        check("nofwd_taken", 16'(bus.branch_taken), 16'h0);
        check("nofwd_ccr", 16'(bus.ccr), 16'h1);
`endif

        // JMP and JC with clear flags.
        wr(3'b111, 16'h0000);
        tick();
        br(2'b11);
        tick();
        check("jmp_taken", 16'(bus.branch_taken), 16'h1);
        check("jmp_ccr", 16'(bus.ccr), 16'h0);
        br(2'b10);
        tick();
        check("jc_taken", 16'(bus.branch_taken), 16'h0);

        // Save+restore together, then JN.
        wr(3'b111, 16'h0002);
        tick();
        bus.int_save = 1'b1; wr(3'b111, 16'h0004);
        tick();
        check("sv_ccr", 16'(bus.ccr), 16'h4);
        bus.int_save = 1'b1; bus.rti_restore = 1'b1;
        tick();
        check("both_err", 16'(bus.stack_err), 16'h1);
        check("both_ccr", 16'(bus.ccr), 16'h2);
        bus.rti_restore = 1'b1;
        tick();
        check("both_drop", 16'(bus.stack_err), 16'h1);
        br(2'b01);
        tick();
        check("jn_taken", 16'(bus.branch_taken), 16'h1);
        check("jn_clear", 16'(bus.ccr), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
